// File: rtl/m_nco_pkg.sv
// -----------------------------------------------------------------------------
// m_nco_pkg
// Shared constants for the numerically controlled oscillator and the
// constant function that produces the quarter-wave sine table.
//   ACC_W    phase accumulator width
//   PHASE_W  truncated phase word width (quadrant + ROM index)
//   OUT_W    two's complement sample width
//   ROM_AW   quarter-wave ROM address width
// -----------------------------------------------------------------------------
package m_nco_pkg;

    localparam int ACC_W        = 32;
    localparam int PHASE_W      = 12;
    localparam int OUT_W        = 10;
    localparam int ROM_AW       = 10;
    localparam int ROM_DW       = OUT_W - 1;
    localparam int ROM_DEPTH    = 1 << ROM_AW;
    localparam int AMPLITUDE    = (1 << ROM_DW) - 1;
    localparam int LFSR_W       = 16;
    localparam int DITHER_SHIFT = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam real               PI        = 3.14159265358979323846;

    // Quarter-wave entry: the half-index offset centres every entry inside
    // its phase bin, so the fold is symmetric and the value 0 appears only
    // as a rounded result of a tiny positive angle.
    function automatic logic [ROM_DW-1:0] qrom_value(input int idx);
        real ang;
        real amp;
        ang = (PI / 2.0) * ($itor(idx) + 0.5) / $itor(ROM_DEPTH);
        amp = $itor(AMPLITUDE) * $sin(ang);
        return ROM_DW'($rtoi(amp + 0.5));
    endfunction

endpackage

// File: rtl/m_nco_qrom.sv
// -----------------------------------------------------------------------------
// m_nco_qrom
// Dual-read-port quarter-wave sine ROM with registered outputs.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset (clears the read registers)
//   en       read enable; read registers hold when 0
//   addr_a   port A address (sine path)
//   addr_b   port B address (cosine path)
//   data_a   port A registered data
//   data_b   port B registered data
// -----------------------------------------------------------------------------
module m_nco_qrom
    import m_nco_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr_a,
    input  logic [ROM_AW-1:0] addr_b,
    output logic [ROM_DW-1:0] data_a,
    output logic [ROM_DW-1:0] data_b
);

    logic [ROM_DW-1:0] rom_table [ROM_DEPTH];
    logic [ROM_DW-1:0] data_a_reg;
    logic [ROM_DW-1:0] data_b_reg;

    // Table contents are fixed at elaboration time.
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        localparam logic [ROM_DW-1:0] ENTRY = qrom_value(gi);
        assign rom_table[gi] = ENTRY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_a_reg <= '0;
            data_b_reg <= '0;
        end else if (en) begin
            data_a_reg <= rom_table[addr_a];
            data_b_reg <= rom_table[addr_b];
        end
    end

    assign data_a = data_a_reg;
    assign data_b = data_b_reg;

endmodule

// File: rtl/m_nco.sv
// -----------------------------------------------------------------------------
// m_nco
// Quadrature numerically controlled oscillator: phase accumulator, quarter
// wave ROM and sign/fold stage, three enabled clocks of latency.
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   clken      clock enable; every register holds when 0
//   phi_inc_i  unsigned phase increment per enabled cycle
//   fsin_o     sine sample, two's complement, -511..+511
//   fcos_o     cosine sample, two's complement, -511..+511
//   out_valid  high once the pipeline has filled after reset
// Build option: define M_NCO_DITHER_EN to add LFSR phase dither ahead of
// the phase truncation.
// -----------------------------------------------------------------------------
module m_nco
    import m_nco_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clken,
    input  logic [ACC_W-1:0] phi_inc_i,
    output logic [OUT_W-1:0] fsin_o,
    output logic [OUT_W-1:0] fcos_o,
    output logic             out_valid
);

    // S1: accumulator and captured phase word
    logic [ACC_W-1:0]   acc_reg;
    logic [PHASE_W-1:0] phase_next;
    logic [PHASE_W-1:0] phase_reg;

    // Fold decode from the captured phase
    logic [1:0]         sin_quad;
    logic [1:0]         cos_quad;
    logic [ROM_AW-1:0]  rom_idx;
    logic [ROM_AW-1:0]  sin_addr;
    logic [ROM_AW-1:0]  cos_addr;

    // S2: ROM data plus the sign flags travelling alongside it
    logic [ROM_DW-1:0]  sin_mag;
    logic [ROM_DW-1:0]  cos_mag;
    logic               sin_neg_reg;
    logic               cos_neg_reg;

    // S3: output registers
    logic [OUT_W-1:0]   fsin_reg;
    logic [OUT_W-1:0]   fcos_reg;
    logic [2:0]         valid_reg;

`ifdef M_NCO_DITHER_EN
    logic [LFSR_W-1:0]  lfsr_reg;
    logic               lfsr_fb;
    logic [ACC_W-1:0]   dither_sum;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (clken) begin
            lfsr_reg <= {lfsr_reg[LFSR_W-2:0], lfsr_fb};
        end
    end

    // Dither sits just below the truncation point so it only randomises the
    // rounding of the discarded fraction.
    assign dither_sum = acc_reg +
                        {{(ACC_W-LFSR_W-DITHER_SHIFT){1'b0}}, lfsr_reg, {DITHER_SHIFT{1'b0}}};
    assign phase_next = dither_sum[ACC_W-1 -: PHASE_W];
`else
    assign phase_next = acc_reg[ACC_W-1 -: PHASE_W];
`endif

    // S1: the phase is taken from the accumulator before this edge's update,
    // so sample k carries phase k*phi_inc_i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg   <= '0;
            phase_reg <= '0;
        end else if (clken) begin
            acc_reg   <= acc_reg + phi_inc_i;
            phase_reg <= phase_next;
        end
    end

    // Cosine is the sine fold a quarter turn later: same index, next quadrant.
    // Odd quadrants read the table mirrored; 1023-i is the bitwise inverse.
    assign sin_quad = phase_reg[PHASE_W-1 -: 2];
    assign cos_quad = sin_quad + 2'd1;
    assign rom_idx  = phase_reg[ROM_AW-1:0];
    assign sin_addr = sin_quad[0] ? ~rom_idx : rom_idx;
    assign cos_addr = cos_quad[0] ? ~rom_idx : rom_idx;

    m_nco_qrom u_qrom (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clken),
        .addr_a  (sin_addr),
        .addr_b  (cos_addr),
        .data_a  (sin_mag),
        .data_b  (cos_mag)
    );

    // S2 sign flags, aligned with the registered ROM read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_neg_reg <= 1'b0;
            cos_neg_reg <= 1'b0;
        end else if (clken) begin
            sin_neg_reg <= sin_quad[1];
            cos_neg_reg <= cos_quad[1];
        end
    end

    // S3: the magnitude never exceeds 511, so negation cannot reach -512.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsin_reg  <= '0;
            fcos_reg  <= '0;
            valid_reg <= '0;
        end else if (clken) begin
            fsin_reg  <= sin_neg_reg ? -{1'b0, sin_mag} : {1'b0, sin_mag};
            fcos_reg  <= cos_neg_reg ? -{1'b0, cos_mag} : {1'b0, cos_mag};
            valid_reg <= {valid_reg[1:0], 1'b1};
        end
    end

    assign fsin_o    = fsin_reg;
    assign fcos_o    = fcos_reg;
    assign out_valid = valid_reg[2];

endmodule

// File: tb/tb_m_nco.sv
// -----------------------------------------------------------------------------
// tb_m_nco
// Directed checks of the NCO: reset state, pipeline fill, quadrant points of
// several tones, clock-enable hold, asynchronous mid-stream reset and a full
// phase sweep with amplitude, power, symmetry and spot-value checks.
// -----------------------------------------------------------------------------
module tb_m_nco;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [31:0] phi_inc_i;
    logic [9:0]  fsin_o;
    logic [9:0]  fcos_o;
    logic        out_valid;

    int n_vec = 0;
    int n_bad = 0;

    // Quadrant points: phase 0, 90, 180, 270 degrees
    int exp_sin [4] = '{0, 511, 0, -511};
    int exp_cos [4] = '{511, 0, -511, 0};

    int sw_sin [4096];
    int sw_cos [4096];

    always #5 clk = ~clk;

    m_nco dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phi_inc_i (phi_inc_i),
        .fsin_o    (fsin_o),
        .fcos_o    (fcos_o),
        .out_valid (out_valid)
    );

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int s_sin();
        return int'($signed(fsin_o));
    endfunction

    function automatic int s_cos();
        return int'($signed(fcos_o));
    endfunction

    // Reset, release on a falling edge and run the three fill edges,
    // leaving sample k0 on the outputs.
    task automatic restart(input logic [31:0] phi);
        @(negedge clk);
        reset_n   = 1'b0;
        clken     = 1'b1;
        phi_inc_i = phi;
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("fill_e1_valid", 32'(out_valid), 0);
        step();
        check_val("fill_e2_valid", 32'(out_valid), 0);
        step();
        check_val("fill_e3_valid", 32'(out_valid), 1);
    endtask

    // Check sample k of the 1/20-cycle tone where a quadrant point is known.
    task automatic check_tone20(input int k);
        $display("tone20 k=%0d sin=%0d cos=%0d valid=%0d", k, s_sin(), s_cos(), out_valid);
        if (k % 5 == 0) begin
            check_val($sformatf("tone20_sin_k%0d", k), s_sin(), exp_sin[(k / 5) % 4]);
            check_val($sformatf("tone20_cos_k%0d", k), s_cos(), exp_cos[(k / 5) % 4]);
        end
    endtask

    initial begin
        int hold_sin;
        int hold_cos;
        int pwr;

        reset_n   = 1'b0;
        clken     = 1'b0;
        phi_inc_i = 32'h0;
        #23;
        $display("reset sin=%0d cos=%0d valid=%0d", s_sin(), s_cos(), out_valid);
        check_val("rst_sin", s_sin(), 0);
        check_val("rst_cos", s_cos(), 0);
        check_val("rst_valid", 32'(out_valid), 0);

        // Tone at f_clk/20 with a clock-enable gap in the middle
        restart(32'h0CCCCCCD);
        for (int k = 0; k <= 22; k++) begin
            check_tone20(k);
            if (k < 22) step();
        end
        clken    = 1'b0;
        hold_sin = s_sin();
        hold_cos = s_cos();
        for (int c = 0; c < 5; c++) begin
            step();
            $display("hold c=%0d sin=%0d cos=%0d valid=%0d", c, s_sin(), s_cos(), out_valid);
            check_val("hold_sin", s_sin(), hold_sin);
            check_val("hold_cos", s_cos(), hold_cos);
            check_val("hold_valid", 32'(out_valid), 1);
        end
        clken = 1'b1;
        for (int k = 23; k <= 45; k++) begin
            step();
            check_tone20(k);
        end

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        $display("async_rst sin=%0d cos=%0d valid=%0d", s_sin(), s_cos(), out_valid);
        check_val("arst_sin", s_sin(), 0);
        check_val("arst_cos", s_cos(), 0);
        check_val("arst_valid", 32'(out_valid), 0);
        step();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("arst_e1_valid", 32'(out_valid), 0);
        step();
        check_val("arst_e2_valid", 32'(out_valid), 0);
        step();
        check_val("arst_e3_valid", 32'(out_valid), 1);
        for (int k = 0; k <= 10; k++) begin
            check_tone20(k);
            if (k < 10) step();
        end

        // DC tone
        restart(32'h0);
        for (int k = 0; k < 10; k++) begin
            $display("dc k=%0d sin=%0d cos=%0d", k, s_sin(), s_cos());
            check_val("dc_sin", s_sin(), 0);
            check_val("dc_cos", s_cos(), 511);
            step();
        end

        // Quarter-rate tone
        restart(32'h40000000);
        for (int k = 0; k < 8; k++) begin
            $display("quarter k=%0d sin=%0d cos=%0d", k, s_sin(), s_cos());
            check_val("qtr_sin", s_sin(), exp_sin[k % 4]);
            check_val("qtr_cos", s_cos(), exp_cos[k % 4]);
            step();
        end

        // Full sweep: sample k carries phase word P = k
        restart(32'h00100000);
        for (int k = 0; k < 4096; k++) begin
            sw_sin[k] = s_sin();
            sw_cos[k] = s_cos();
            pwr = sw_sin[k] * sw_sin[k] + sw_cos[k] * sw_cos[k];
            check_val($sformatf("sweep_sin_range_p%0d", k),
                      32'(sw_sin[k] >= -511 && sw_sin[k] <= 511), 1);
            check_val($sformatf("sweep_cos_range_p%0d", k),
                      32'(sw_cos[k] >= -511 && sw_cos[k] <= 511), 1);
            check_val($sformatf("sweep_power_p%0d(%0d)", k, pwr),
                      32'(pwr >= 511 * 511 - 1100 && pwr <= 511 * 511 + 1100), 1);
            step();
        end
        $display("sweep done p511=%0d p512=%0d p1024=%0d", sw_sin[511], sw_sin[512], sw_sin[1024]);
        check_val("sweep_sin_p0", sw_sin[0], 0);
        check_val("sweep_sin_p511", sw_sin[511], 361);
        check_val("sweep_sin_p512", sw_sin[512], 362);
        check_val("sweep_sin_p1024", sw_sin[1024], 511);
        check_val("sweep_cos_p0", sw_cos[0], 511);
        // Half-sample centring makes sine symmetric about P=1023.5
        for (int k = 0; k < 1024; k++)
            check_val($sformatf("sweep_mirror_p%0d", k), sw_sin[k], sw_sin[2047 - k]);
        for (int k = 0; k < 2048; k++)
            check_val($sformatf("sweep_antisym_p%0d", k), sw_sin[k], -sw_sin[k + 2048]);
        for (int k = 0; k < 4096; k++)
            check_val($sformatf("sweep_cos_shift_p%0d", k), sw_cos[k], sw_sin[(k + 1024) % 4096]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
